led_fader: RTL and testbench

Output stage between the LED pattern generator and the board LED pins. Consumes the generator's 8-bit pattern (Gray-code count or LFSR bits) and turns each hard on/off bit into a PWM-dimmed LED level that ramps up while the bit is set and decays exponentially when it clears, giving a comet-trail effect. Per-channel levels update on a slow fade tick. Duty changes take effect only at PWM period boundaries, so the LED pins never glitch.

---
 rtl/led_pkg.sv | 46 ++++
 rtl/led_fade_channel.sv | 53 +++++
 rtl/led_fader.sv | 63 ++++++
 tb/tb_led_fader.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared constants and level-step arithmetic for the LED output stages.
// Level math runs at a fixed 16-bit width so any PWM width up to 16 can reuse it.
package led_pkg;

    localparam int unsigned CHANNELS_DEF    = 8;
    localparam int unsigned PWM_BITS_DEF    = 8;
    localparam int unsigned FADE_LOG2_DEF   = 14;
    localparam int unsigned RISE_STEP_DEF   = 32;
    localparam int unsigned DECAY_SHIFT_DEF = 3;
    localparam int unsigned LVL_W           = 16;

    typedef enum logic [1:0] {
        FADE_HOLD  = 2'd0,
        FADE_RISE  = 2'd1,
        FADE_DECAY = 2'd2
    } fade_op_e;

    function automatic fade_op_e fade_sel(input logic tick, input logic bit_on,
                                          input logic nonzero);
        if (!tick)        return FADE_HOLD;
        else if (bit_on)  return FADE_RISE;
        else if (nonzero) return FADE_DECAY;
        else              return FADE_HOLD;
    endfunction

    // One extra bit on the sum so a large step saturates instead of wrapping.
    function automatic logic [LVL_W-1:0] sat_rise(input logic [LVL_W-1:0] level,
                                                  input logic [LVL_W-1:0] step,
                                                  input logic [LVL_W-1:0] max_val);
        logic [LVL_W:0] sum;
        sum = {1'b0, level} + {1'b0, step};
        if (sum > {1'b0, max_val}) return max_val;
        return sum[LVL_W-1:0];
    endfunction

    // Exponential decay with a minimum step of one so small levels still reach zero.
    function automatic logic [LVL_W-1:0] decay_step(input logic [LVL_W-1:0] level,
                                                    input int unsigned shift);
        logic [LVL_W-1:0] dec;
        if (level == '0) return '0;
        dec = level >> shift;
        if (dec == '0) dec = LVL_W'(1);
        return level - dec;
    endfunction

endpackage

// File: rtl/led_fade_channel.sv
// One LED channel: fade level register, period-aligned shadow copy and PWM compare.
module led_fade_channel
    import led_pkg::*;
#(
    parameter int unsigned PWM_BITS    = PWM_BITS_DEF,
    parameter int unsigned RISE_STEP   = RISE_STEP_DEF,
    parameter int unsigned DECAY_SHIFT = DECAY_SHIFT_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                tick,
    input  logic                shadow_load,
    input  logic                pattern_bit,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led
);

    localparam logic [LVL_W-1:0] MAX_LVL = LVL_W'((1 << PWM_BITS) - 1);

    logic [PWM_BITS-1:0] level_q, level_d;
    logic [PWM_BITS-1:0] shadow_q, shadow_d;
    logic                led_q, led_d;
    fade_op_e            op;

    always_comb begin
        op      = fade_sel(tick, pattern_bit, level_q != '0);
        level_d = level_q;
        case (op)
            FADE_RISE:  level_d = PWM_BITS'(sat_rise(LVL_W'(level_q), LVL_W'(RISE_STEP), MAX_LVL));
            FADE_DECAY: level_d = PWM_BITS'(decay_step(LVL_W'(level_q), DECAY_SHIFT));
            default:    level_d = level_q;
        endcase
        // Shadow samples the pre-tick level, so duty only changes at period starts.
        shadow_d = shadow_load ? level_q : shadow_q;
        led_d    = en && (shadow_q > pwm_cnt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q  <= '0;
            shadow_q <= '0;
            led_q    <= 1'b0;
        end else begin
            level_q  <= level_d;
            shadow_q <= shadow_d;
            led_q    <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: rtl/led_fader.sv
// PWM fade output stage: prescaled fade tick, shared PWM counter and per-channel faders.
module led_fader
    import led_pkg::*;
#(
    parameter int unsigned CHANNELS    = CHANNELS_DEF,
    parameter int unsigned PWM_BITS    = PWM_BITS_DEF,
    parameter int unsigned FADE_LOG2   = FADE_LOG2_DEF,
    parameter int unsigned RISE_STEP   = RISE_STEP_DEF,
    parameter int unsigned DECAY_SHIFT = DECAY_SHIFT_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [CHANNELS-1:0] pattern_in,
    output logic [CHANNELS-1:0] led_out,
    output logic                tick_out
);

    logic [FADE_LOG2-1:0] presc_q, presc_d;
    logic [PWM_BITS-1:0]  pwm_cnt_q, pwm_cnt_d;
    logic                 tick_out_q, tick_out_d;
    logic                 tick, shadow_load;

    always_comb begin
        tick        = en && (presc_q == '1);
        shadow_load = en && (pwm_cnt_q == '1);
        presc_d     = en ? presc_q + FADE_LOG2'(1) : presc_q;
        pwm_cnt_d   = en ? pwm_cnt_q + PWM_BITS'(1) : pwm_cnt_q;
        tick_out_d  = tick;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q    <= '0;
            pwm_cnt_q  <= '0;
            tick_out_q <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            pwm_cnt_q  <= pwm_cnt_d;
            tick_out_q <= tick_out_d;
        end
    end

    assign tick_out = tick_out_q;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        led_fade_channel #(
            .PWM_BITS   (PWM_BITS),
            .RISE_STEP  (RISE_STEP),
            .DECAY_SHIFT(DECAY_SHIFT)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .en         (en),
            .tick       (tick),
            .shadow_load(shadow_load),
            .pattern_bit(pattern_in[i]),
            .pwm_cnt    (pwm_cnt_q),
            .led        (led_out[i])
        );
    end

endmodule

// File: tb/tb_led_fader.sv
// Bench for led_fader with a short fade tick (FADE_LOG2=4) and 8-bit PWM.
module tb_led_fader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] pattern_in;
    logic [7:0] led_out;
    logic       tick_out;

    int checks = 0;
    int errors = 0;

    led_fader #(
        .CHANNELS   (8),
        .PWM_BITS   (8),
        .FADE_LOG2  (4),
        .RISE_STEP  (32),
        .DECAY_SHIFT(3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .pattern_in(pattern_in),
        .led_out   (led_out),
        .tick_out  (tick_out)
    );

    always #5 clk = ~clk;

    logic [63:0] dut_levels;
    assign dut_levels = {dut.g_ch[7].u_ch.level_q, dut.g_ch[6].u_ch.level_q,
                         dut.g_ch[5].u_ch.level_q, dut.g_ch[4].u_ch.level_q,
                         dut.g_ch[3].u_ch.level_q, dut.g_ch[2].u_ch.level_q,
                         dut.g_ch[1].u_ch.level_q, dut.g_ch[0].u_ch.level_q};

    // Scoreboard of expected level vectors, one entry per upcoming fade tick.
    logic [63:0] exp_q[$];
    int          m_level[8];

    function automatic int model_rise(input int l);
        return (l + 32 > 255) ? 255 : l + 32;
    endfunction

    function automatic int model_decay(input int l);
        int d;
        if (l == 0) return 0;
        d = l / 8;
        if (d < 1) d = 1;
        return l - d;
    endfunction

    task automatic model_tick(input logic [7:0] pat);
        for (int i = 0; i < 8; i++)
            m_level[i] = pat[i] ? model_rise(m_level[i]) : model_decay(m_level[i]);
    endtask

    function automatic logic [63:0] model_vec();
        logic [63:0] v;
        for (int i = 0; i < 8; i++) v[i*8 +: 8] = 8'(m_level[i]);
        return v;
    endfunction

    // Per-period high counts, gathered only over cycles in which the PWM counter advanced.
    int         acc[8];
    int         acc_len;
    int         period_hi[8];
    int         period_len = 0;
    int         period_seq = 0;
    logic [7:0] prev_cnt = 8'd0;

    initial begin
        for (int i = 0; i < 8; i++) begin acc[i] = 0; period_hi[i] = 0; end
        acc_len = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                for (int i = 0; i < 8; i++) acc[i] = 0;
                acc_len  = 0;
                prev_cnt = dut.pwm_cnt_q;
            end else if (dut.pwm_cnt_q != prev_cnt) begin
                for (int i = 0; i < 8; i++) acc[i] += int'(led_out[i]);
                acc_len++;
                if (dut.pwm_cnt_q == 8'd0) begin
                    for (int i = 0; i < 8; i++) begin period_hi[i] = acc[i]; acc[i] = 0; end
                    period_len = acc_len;
                    acc_len    = 0;
                    period_seq++;
                end
                prev_cnt = dut.pwm_cnt_q;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s timed out waiting for DUT", name);
    endtask

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (tick_out === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_pwm(input logic [7:0] v, input bit need_tick, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1100; i++) begin
            step();
            if (dut.pwm_cnt_q == v && (!need_tick || tick_out === 1'b1)) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_seq(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1100; i++) begin
            if (period_seq >= target) begin ok = 1'b1; break; end
            step();
        end
    endtask

    task automatic test_reset();
        int c, first, last, bad_iv, led_bad;
        rst_n = 1'b0; en = 1'b1; pattern_in = 8'h00;
        repeat (3) step();
        checks++;
        if (led_out !== 8'h00) begin errors++; $display("FAIL reset_led got %h want 00", led_out); end
        checks++;
        if (tick_out !== 1'b0) begin errors++; $display("FAIL reset_tick got %b want 0", tick_out); end
        checks++;
        if (dut_levels !== 64'd0) begin errors++; $display("FAIL reset_levels got %h want 0", dut_levels); end
        rst_n = 1'b1;
        c = 1; first = -1; last = -1; bad_iv = 0; led_bad = 0;
        for (int k = 0; k < 1024; k++) begin
            @(posedge clk);
            c++;
            @(negedge clk);
            #1;
            if (led_out !== 8'h00) led_bad++;
            if (tick_out === 1'b1) begin
                if (first < 0) first = c;
                else if (c - last != 16) bad_iv++;
                last = c;
            end
        end
        checks++;
        if (first != 17) begin errors++; $display("FAIL first_tick got cycle %0d want 17", first); end
        checks++;
        if (bad_iv != 0) begin errors++; $display("FAIL tick_interval got %0d bad intervals want 0", bad_iv); end
        checks++;
        if (led_bad != 0) begin errors++; $display("FAIL dark_after_reset got %0d lit cycles want 0", led_bad); end
    endtask

    task automatic test_rise();
        bit ok;
        int target;
        logic [63:0] exp;
        target = 0;
        wait_pwm(8'd224, 1'b1, ok);
        if (!ok) begin timeout_fail("rise_sync"); return; end
        pattern_in = 8'h01;
        for (int i = 0; i < 8; i++) m_level[i] = 0;
        for (int i = 0; i < 10; i++) begin model_tick(8'h01); exp_q.push_back(model_vec()); end
        for (int i = 0; i < 10; i++) begin
            wait_tick(ok);
            if (!ok) begin timeout_fail("rise_tick"); exp_q.delete(); return; end
            exp = exp_q.pop_front();
            checks++;
            if (dut_levels !== exp) begin
                errors++;
                $display("FAIL rise_level tick %0d got %h want %h", i + 1, dut_levels, exp);
            end
            if (i == 1) target = period_seq + 1;
        end
        wait_seq(target, ok);
        if (!ok) begin timeout_fail("rise_period"); return; end
        checks++;
        if (period_hi[0] != 32) begin errors++; $display("FAIL rise_duty got %0d high want 32", period_hi[0]); end
        checks++;
        if (period_len != 256) begin errors++; $display("FAIL period_len got %0d want 256", period_len); end
        checks++;
        if (period_hi[1] + period_hi[2] + period_hi[3] + period_hi[4] + period_hi[5] +
            period_hi[6] + period_hi[7] != 0) begin
            errors++; $display("FAIL rise_others got nonzero high count want 0");
        end
    endtask

    task automatic test_decay();
        bit ok;
        logic [63:0] exp;
        wait_tick(ok);
        if (!ok) begin timeout_fail("decay_sync"); return; end
        pattern_in = 8'h00;
        for (int i = 0; i < 8; i++) m_level[i] = 0;
        m_level[0] = 255;
        for (int i = 0; i < 44; i++) begin model_tick(8'h00); exp_q.push_back(model_vec()); end
        for (int i = 0; i < 44; i++) begin
            wait_tick(ok);
            if (!ok) begin timeout_fail("decay_tick"); exp_q.delete(); return; end
            exp = exp_q.pop_front();
            checks++;
            if (dut_levels !== exp) begin
                errors++;
                $display("FAIL decay_level tick %0d got %h want %h", i + 1, dut_levels, exp);
            end
        end
    endtask

    task automatic test_midperiod();
        bit ok;
        int s, lv;
        logic [63:0] exp;
        wait_pwm(8'd112, 1'b1, ok);
        if (!ok) begin timeout_fail("mid_sync"); return; end
        pattern_in = 8'h02;
        for (int i = 0; i < 8; i++) m_level[i] = 0;
        model_tick(8'h02);
        exp_q.push_back(model_vec());
        wait_tick(ok);
        if (!ok) begin timeout_fail("mid_tick"); exp_q.delete(); return; end
        pattern_in = 8'h00;
        s = period_seq;
        exp = exp_q.pop_front();
        checks++;
        if (dut_levels !== exp) begin errors++; $display("FAIL mid_level got %h want %h", dut_levels, exp); end
        lv = m_level[1];
        repeat (7) lv = model_decay(lv);
        wait_seq(s + 1, ok);
        if (!ok) begin timeout_fail("mid_period_cur"); return; end
        checks++;
        if (period_hi[1] != 0) begin errors++; $display("FAIL mid_cur_period got %0d high want 0", period_hi[1]); end
        wait_seq(s + 2, ok);
        if (!ok) begin timeout_fail("mid_period_next"); return; end
        checks++;
        if (period_hi[1] != lv) begin errors++; $display("FAIL mid_next_period got %0d high want %0d", period_hi[1], lv); end
    endtask

    task automatic test_enable();
        bit ok;
        int s, bad;
        pattern_in = 8'h01;
        repeat (600) step();
        wait_pwm(8'd100, 1'b0, ok);
        if (!ok) begin timeout_fail("en_sync"); return; end
        en = 1'b0;
        s = period_seq;
        step();
        checks++;
        if (led_out !== 8'h00) begin errors++; $display("FAIL en_led_off got %h want 00", led_out); end
        bad = 0;
        repeat (40) begin
            step();
            if (led_out !== 8'h00 || tick_out !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL en_outputs_idle got %0d active cycles want 0", bad); end
        checks++;
        if (dut.pwm_cnt_q !== 8'd100) begin errors++; $display("FAIL en_pwm_hold got %0d want 100", dut.pwm_cnt_q); end
        checks++;
        if (dut.presc_q !== 4'd4) begin errors++; $display("FAIL en_presc_hold got %0d want 4", dut.presc_q); end
        checks++;
        if (dut_levels !== 64'h00000000000000FF) begin
            errors++; $display("FAIL en_level_hold got %h want ff", dut_levels);
        end
        en = 1'b1;
        wait_seq(s + 1, ok);
        if (!ok) begin timeout_fail("en_resume"); return; end
        checks++;
        if (period_hi[0] != 255) begin errors++; $display("FAIL en_resume_duty got %0d high want 255", period_hi[0]); end
        checks++;
        if (period_len != 256) begin errors++; $display("FAIL en_resume_len got %0d want 256", period_len); end
    endtask

    task automatic test_async_reset();
        bit ok;
        pattern_in = 8'h05;
        repeat (3) begin
            wait_tick(ok);
            if (!ok) begin timeout_fail("ar_tick"); return; end
        end
        pattern_in = 8'h01;
        wait_pwm(8'd50, 1'b0, ok);
        if (!ok) begin timeout_fail("ar_sync"); return; end
        checks++;
        if (led_out[0] !== 1'b1) begin errors++; $display("FAIL ar_precondition got led0=%b want 1", led_out[0]); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (led_out !== 8'h00) begin errors++; $display("FAIL ar_led_async got %h want 00", led_out); end
        checks++;
        if (dut_levels !== 64'd0) begin errors++; $display("FAIL ar_levels got %h want 0", dut_levels); end
        checks++;
        if (dut.pwm_cnt_q !== 8'd0) begin errors++; $display("FAIL ar_pwm got %0d want 0", dut.pwm_cnt_q); end
        step();
        pattern_in = 8'h00;
        rst_n = 1'b1;
        repeat (40) step();
        checks++;
        if (dut_levels !== 64'd0) begin errors++; $display("FAIL ar_levels_after got %h want 0", dut_levels); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_rise();
        test_decay();
        test_midperiod();
        test_enable();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
